// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture pipeline: default image geometry,
// the classifier FSM state type and finger bin indices.
package gesture_pkg;

  localparam int unsigned DEF_COORD_W = 8;
  localparam int unsigned DEF_IMG_W   = 160;
  localparam int unsigned DEF_IMG_H   = 120;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam int unsigned THUMB  = 0;
  localparam int unsigned INDEX  = 1;
  localparam int unsigned MIDDLE = 2;
  localparam int unsigned RING   = 3;
  localparam int unsigned PINKY  = 4;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column tracker for a pixel stream. Reports the
// coordinates of the current beat (sof forces the origin) and flags the
// last pixel of the frame. Advances only on enabled beats.
module raster_counter
  import gesture_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sof,
  output logic [COORD_W-1:0] row_c,
  output logic [COORD_W-1:0] col_c,
  output logic               last_c
);

  logic [COORD_W-1:0] row_q;
  logic [COORD_W-1:0] col_q;

  // Coordinates of the beat on the bus this cycle
  always_comb begin
    row_c  = sof ? '0 : row_q;
    col_c  = sof ? '0 : col_q;
    last_c = (row_c == COORD_W'(IMG_H - 1)) && (col_c == COORD_W'(IMG_W - 1));
  end

  // Step to the position following the current beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      if (col_c == COORD_W'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_c == COORD_W'(IMG_H - 1)) ? '0 : row_c + COORD_W'(1);
      end else begin
        col_q <= col_c + COORD_W'(1);
        row_q <= row_c;
      end
    end
  end

endmodule

// File: rtl/finger_zone_classifier.sv
// Counts skin pixels in the zone directly above the palm box, split into
// NUM_FINGERS equal column bins, and emits one extended/folded bit per bin
// once per frame.
module finger_zone_classifier
  import gesture_pkg::*;
#(
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned IMG_H       = DEF_IMG_H,
  parameter int unsigned COORD_W     = DEF_COORD_W,
  parameter int unsigned NUM_FINGERS = 5,
  parameter int unsigned CNT_W       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   palm_valid,
  input  logic [COORD_W-1:0]     palm_start_r,
  input  logic [COORD_W-1:0]     palm_start_c,
  input  logic [COORD_W-1:0]     palm_end_r,
  input  logic [COORD_W-1:0]     palm_end_c,
  input  logic [COORD_W-1:0]     zone_rows,
  input  logic [CNT_W-1:0]       thresh,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic                   pix_data,
  output logic [NUM_FINGERS-1:0] finger_status,
  output logic                   status_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned W_W   = COORD_W + 1;
  localparam int unsigned ACC_W = COORD_W + 2;
  localparam int unsigned BIN_W = $clog2(NUM_FINGERS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [COORD_W-1:0] start_r_q, start_c_q, end_c_q, zone_lo_q;
  logic [W_W-1:0]     width_q;
  logic [CNT_W-1:0]   thresh_q;
  logic [ACC_W-1:0]   acc_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   bin_cnt [NUM_FINGERS];

  logic               sof_beat, last_c, box_ok, in_zone, row_first, take;
  logic [COORD_W-1:0] row_c, col_c, zone_lo_in;
  logic [COORD_W-1:0] eff_start_r, eff_start_c, eff_end_c, eff_zone_lo;
  logic [W_W-1:0]     width_in, eff_width;
  logic [ACC_W-1:0]   acc_base, acc_sum, acc_next;
  logic [BIN_W-1:0]   bin_base, bin_next;
  logic [CNT_W-1:0]   cnt_next [NUM_FINGERS];

  assign sof_beat = pix_valid & pix_sof;
  assign busy     = (state != IDLE);

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .COORD_W(COORD_W)
  ) u_raster (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_valid),
    .sof   (sof_beat),
    .row_c (row_c),
    .col_c (col_c),
    .last_c(last_c)
  );

  // Decode the incoming palm box: width, clamped zone top, validity
  always_comb begin
    width_in   = W_W'(palm_end_c) - W_W'(palm_start_c) + W_W'(1);
    zone_lo_in = (palm_start_r > zone_rows) ? palm_start_r - zone_rows : '0;
    box_ok     = palm_valid && (palm_end_c >= palm_start_c) &&
                 (palm_end_r >= palm_start_r) && (width_in >= W_W'(NUM_FINGERS));
  end

  // Zone membership, Bresenham bin stepping and next bin counts for this beat
  always_comb begin
    eff_start_r = sof_beat ? palm_start_r : start_r_q;
    eff_start_c = sof_beat ? palm_start_c : start_c_q;
    eff_end_c   = sof_beat ? palm_end_c   : end_c_q;
    eff_zone_lo = sof_beat ? zone_lo_in   : zone_lo_q;
    eff_width   = sof_beat ? width_in     : width_q;

    in_zone   = (row_c >= eff_zone_lo) && (row_c < eff_start_r) &&
                (col_c >= eff_start_c) && (col_c <= eff_end_c);
    row_first = (col_c == eff_start_c);
    acc_base  = row_first ? '0 : acc_q;
    bin_base  = row_first ? '0 : bin_q;
    acc_sum   = acc_base + ACC_W'(NUM_FINGERS);
    if (acc_sum >= ACC_W'(eff_width)) begin
      acc_next = acc_sum - ACC_W'(eff_width);
      bin_next = bin_base + BIN_W'(1);
    end else begin
      acc_next = acc_sum;
      bin_next = bin_base;
    end

    take = sof_beat ? box_ok : (pix_valid && (state == SCAN));

    for (int i = THUMB; i < NUM_FINGERS; i++) begin
      cnt_next[i] = sof_beat ? '0 : bin_cnt[i];
      if (in_zone && pix_data && (bin_base == BIN_W'(i)) && (cnt_next[i] != CNT_MAX))
        cnt_next[i] = cnt_next[i] + CNT_W'(1);
    end
  end

  // Frame FSM, box latching, bin counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      start_r_q     <= '0;
      start_c_q     <= '0;
      end_c_q       <= '0;
      zone_lo_q     <= '0;
      width_q       <= '0;
      thresh_q      <= '0;
      acc_q         <= '0;
      bin_q         <= '0;
      finger_status <= '0;
      status_valid  <= 1'b0;
      err           <= 1'b0;
      for (int i = 0; i < NUM_FINGERS; i++) bin_cnt[i] <= '0;
    end else begin
      status_valid <= 1'b0;
      err          <= 1'b0;

      if (sof_beat) begin
        start_r_q <= palm_start_r;
        start_c_q <= palm_start_c;
        end_c_q   <= palm_end_c;
        zone_lo_q <= zone_lo_in;
        width_q   <= width_in;
        thresh_q  <= thresh;
      end

      if (take) begin
        for (int i = 0; i < NUM_FINGERS; i++) bin_cnt[i] <= cnt_next[i];
        if (in_zone) begin
          acc_q <= acc_next;
          bin_q <= bin_next;
        end
      end

      case (state)
        IDLE: begin
          if (sof_beat) begin
            if (box_ok) begin
              state <= SCAN;
            end else begin
              err           <= 1'b1;
              finger_status <= '0;
              status_valid  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (sof_beat) begin
            err <= 1'b1;
            if (!box_ok) begin
              finger_status <= '0;
              status_valid  <= 1'b1;
              state         <= IDLE;
            end
          end else if (pix_valid && last_c) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          for (int i = 0; i < NUM_FINGERS; i++)
            finger_status[i] <= (bin_cnt[i] >= thresh_q);
          status_valid <= 1'b1;
          state        <= (sof_beat && box_ok) ? SCAN : IDLE;
          if (sof_beat && !box_ok) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_finger_zone_classifier.sv
// Directed bench for finger_zone_classifier on a 16x16 image.
module tb_finger_zone_classifier;

  localparam int unsigned IW  = 16;
  localparam int unsigned IH  = 16;
  localparam int unsigned CW  = 8;
  localparam int unsigned NF  = 5;
  localparam int unsigned CTW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          palm_valid;
  logic [CW-1:0] palm_start_r, palm_start_c, palm_end_r, palm_end_c, zone_rows;
  logic [CTW-1:0] thresh;
  logic          pix_valid, pix_sof, pix_data;
  logic [NF-1:0] finger_status;
  logic          status_valid, busy, err;

  int tests = 0;
  int fails = 0;
  int sv_cnt = 0;
  int err_cnt = 0;
  int s0, e0;
  logic [15:0] img [16];

  finger_zone_classifier #(
    .IMG_W(IW), .IMG_H(IH), .COORD_W(CW), .NUM_FINGERS(NF), .CNT_W(CTW)
  ) dut (
    .clk(clk), .rst(rst), .palm_valid(palm_valid),
    .palm_start_r(palm_start_r), .palm_start_c(palm_start_c),
    .palm_end_r(palm_end_r), .palm_end_c(palm_end_c),
    .zone_rows(zone_rows), .thresh(thresh),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .finger_status(finger_status), .status_valid(status_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (status_valid) sv_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int sr, input int sc, input int er, input int ec,
                         input int zr, input int th, input logic pv);
    palm_start_r = CW'(sr);
    palm_start_c = CW'(sc);
    palm_end_r   = CW'(er);
    palm_end_c   = CW'(ec);
    zone_rows    = CW'(zr);
    thresh       = CTW'(th);
    palm_valid   = pv;
  endtask

  task automatic img_fill(input logic v);
    for (int r = 0; r < 16; r++) img[r] = v ? 16'hFFFF : 16'h0000;
  endtask

  // Skin on cols 3,4,7,8 of rows 4..7
  task automatic img_case1();
    img_fill(1'b0);
    for (int r = 4; r < 8; r++) img[r] = 16'h0198;
  endtask

  // Drive rows 0..rows-1 of img, with optional random idle gaps before beats
  task automatic send_frame(input int max_gap, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < 16; c++) begin
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (g) tick();
        pix_valid = 1'b1;
        pix_sof   = (r == 0 && c == 0);
        pix_data  = img[r][c];
        tick();
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 1'b0;
  endtask

  task automatic send_sof_only();
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 1'b0;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_data = 1'b0;
    set_box(8, 3, 14, 12, 4, 4, 1'b1);
    img_fill(1'b0);
    repeat (3) tick();
    check("rst_status", 32'(finger_status), 32'h0);
    check("rst_sv", 32'(status_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // Bins 0 and 2 hold 8 skin pixels each, thresh 4
    img_case1();
    set_box(8, 3, 14, 12, 4, 4, 1'b1);
    send_frame(0, 16);
    check("c1_sv_not_early", 32'(status_valid), 32'h0);
    check("c1_busy_decide", 32'(busy), 32'h1);
    tick();
    check("c1_sv", 32'(status_valid), 32'h1);
    check("c1_status", 32'(finger_status), 32'h05);
    check("c1_err", 32'(err), 32'h0);
    tick();
    check("c1_sv_drop", 32'(status_valid), 32'h0);
    check("c1_busy_idle", 32'(busy), 32'h0);

    // Empty frame, thresh 1
    img_fill(1'b0);
    set_box(8, 3, 14, 12, 4, 1, 1'b1);
    send_frame(0, 16);
    tick();
    check("zero_sv", 32'(status_valid), 32'h1);
    check("zero_status", 32'(finger_status), 32'h0);
    check("zero_err", 32'(err), 32'h0);

    // Zone clamped to rows 0..1, full skin gives 4 per bin
    img_fill(1'b1);
    set_box(2, 3, 14, 12, 4, 5, 1'b1);
    send_frame(0, 16);
    tick();
    check("clamp_t5_status", 32'(finger_status), 32'h00);
    set_box(2, 3, 14, 12, 4, 4, 1'b1);
    send_frame(0, 16);
    tick();
    check("clamp_t4_status", 32'(finger_status), 32'h1F);
    check("clamp_t4_sv", 32'(status_valid), 32'h1);

    // Same as first case with random idle gaps
    img_case1();
    set_box(8, 3, 14, 12, 4, 4, 1'b1);
    send_frame(3, 16);
    tick();
    check("gap_sv", 32'(status_valid), 32'h1);
    check("gap_status", 32'(finger_status), 32'h05);
    tick();

    // Abort at row 9 with a full-skin frame, then a clean case1 frame
    s0 = sv_cnt;
    e0 = err_cnt;
    img_fill(1'b1);
    send_frame(0, 9);
    img_case1();
    send_frame(0, 16);
    check("abort_no_sv", 32'(sv_cnt - s0), 32'h0);
    check("abort_err_cnt", 32'(err_cnt - e0), 32'h1);
    tick();
    check("abort_sv", 32'(status_valid), 32'h1);
    check("abort_status", 32'(finger_status), 32'h05);
    tick();
    check("abort_sv_cnt", 32'(sv_cnt - s0), 32'h1);

    // Asynchronous reset in the middle of a scan
    img_case1();
    send_frame(0, 5);
    check("mid_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_status", 32'(finger_status), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_sv", 32'(status_valid), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(0, 16);
    tick();
    check("post_rst_status", 32'(finger_status), 32'h05);

    // Too-narrow box: W = 3
    tick();
    set_box(8, 3, 14, 5, 4, 4, 1'b1);
    send_sof_only();
    check("narrow_err", 32'(err), 32'h1);
    check("narrow_sv", 32'(status_valid), 32'h1);
    check("narrow_status", 32'(finger_status), 32'h0);
    check("narrow_busy", 32'(busy), 32'h0);

    // Restore a non-zero status, then palm_valid low
    set_box(8, 3, 14, 12, 4, 4, 1'b1);
    send_frame(0, 16);
    tick();
    check("restore_status", 32'(finger_status), 32'h05);
    tick();
    set_box(8, 3, 14, 12, 4, 4, 1'b0);
    send_sof_only();
    check("nopalm_err", 32'(err), 32'h1);
    check("nopalm_sv", 32'(status_valid), 32'h1);
    check("nopalm_status", 32'(finger_status), 32'h0);
    check("nopalm_busy", 32'(busy), 32'h0);
    tick();
    check("nopalm_idle", 32'(busy), 32'h0);
    check("nopalm_err_drop", 32'(err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
